// File: rtl/addsub_accum.sv
// Command-driven 4-bit accumulator around an external combinational adder-subtractor.
// Each command runs for one EXEC cycle; its result is held on a valid/ready port until it is consumed.
module addsub_accum (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] as_x,
    output logic [3:0] as_y,
    output logic       as_select,
    input  logic [3:0] as_result,
    input  logic       as_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_carry,
    output logic       res_ovf,
    output logic       res_zero,
    output logic       res_neg,
    output logic [3:0] acc
);

    localparam int WIDTH = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] acc_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_carry_r;
    logic             res_ovf_r;
    logic             res_zero_r;
    logic             res_neg_r;

    logic             cmd_ready_s;
    logic             as_select_s;
    logic             accept_s;
    logic [WIDTH-1:0] new_acc_s;
    logic             new_carry_s;
    logic             new_ovf_s;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Signed overflow: operands differ in sign and the result leaves the minuend's sign.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign accept_s = cmd_valid && cmd_ready_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (accept_s) begin
                    state_next_s = ST_EXEC;
                end else if (res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State-decoded outputs; cmd_ready also looks at rst so nothing is accepted during reset.
    always_comb begin
        cmd_ready_s = 1'b0;
        as_select_s = 1'b0;
        case (state_r)
            ST_IDLE: cmd_ready_s = !rst;
            ST_EXEC: as_select_s = (op_r == OP_SUB);
            ST_WAIT: cmd_ready_s = !rst && res_ready;
            default: begin
                cmd_ready_s = 1'b0;
                as_select_s = 1'b0;
            end
        endcase
    end

    // New accumulator value and flags for the op latched in EXEC.
    always_comb begin
        new_acc_s   = {WIDTH{1'b0}};
        new_carry_s = 1'b0;
        new_ovf_s   = 1'b0;
        case (op_r)
            OP_LOAD: new_acc_s = opnd_r;
            OP_ADD: begin
                new_acc_s   = as_result;
                new_carry_s = as_cout;
                new_ovf_s   = add_ovf(acc_r, opnd_r, as_result);
            end
            OP_SUB: begin
                new_acc_s   = as_result;
                new_carry_s = as_cout;
                new_ovf_s   = sub_ovf(acc_r, opnd_r, as_result);
            end
            OP_CLR:  new_acc_s = {WIDTH{1'b0}};
            default: new_acc_s = {WIDTH{1'b0}};
        endcase
    end

    // Command latch, accumulator and result registers; results only move in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r        <= OP_LOAD;
            opnd_r      <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
            res_carry_r <= 1'b0;
            res_ovf_r   <= 1'b0;
            res_zero_r  <= 1'b0;
            res_neg_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r   <= cmd_op;
                opnd_r <= cmd_data;
            end
            if (state_r == ST_EXEC) begin
                acc_r       <= new_acc_s;
                res_data_r  <= new_acc_s;
                res_carry_r <= new_carry_s;
                res_ovf_r   <= new_ovf_s;
                res_zero_r  <= (new_acc_s == {WIDTH{1'b0}});
                res_neg_r   <= new_acc_s[WIDTH-1];
                res_valid_r <= 1'b1;
            end else if ((state_r == ST_WAIT) && res_ready) begin
                res_valid_r <= 1'b0;
            end
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign as_x      = acc_r;
    assign as_y      = opnd_r;
    assign as_select = as_select_s;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_carry = res_carry_r;
    assign res_ovf   = res_ovf_r;
    assign res_zero  = res_zero_r;
    assign res_neg   = res_neg_r;
    assign acc       = acc_r;

endmodule

// File: doc/addsub_accum.md
# addsub_accum

Command-driven 4-bit accumulator controller that sits directly upstream of the 4-bit adder-subtractor and consumes its outputs. It drives the adder-subtractor's operand and mode inputs from its own accumulator and operand registers, and captures the sum/difference and carry-out back into the accumulator. Each captured result is presented with status flags on a valid/ready output port. It is the first stateful stage around the combinational add/sub datapath.

## Interface
- WIDTH, 4, datapath width; fixed at 4 to match the adder-subtractor.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- cmd_data  in  4  operand; ignored for CLR.
- as_x  out  4  to adder-subtractor x; always equals acc.
- as_y  out  4  to adder-subtractor y; always equals opnd register.
- as_select  out  1  to adder-subtractor Select; 1 only in EXEC with latched op = SUB, else 0.
- as_result  in  4  from adder-subtractor Result.
- as_cout  in  1  from adder-subtractor Cout.
- res_valid  out  1  result and flags valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  4  captured result (new acc value).
- res_carry  out  1  raw Cout for ADD/SUB; SUB: 1 = no borrow.
- res_ovf  out  1  signed two's-complement overflow.
- res_zero  out  1  res_data == 0.
- res_neg  out  1  res_data[3].
- acc  out  4  current accumulator value.

## Operation
- States: IDLE, EXEC, WAIT.
- cmd_ready = !rst && (state==IDLE || (state==WAIT && res_ready)).
- Accept (cmd_valid && cmd_ready at an edge): latch op into op_reg and cmd_data into opnd. Go to EXEC. When accepted from WAIT, the result handshake completes on the same edge.
- EXEC (exactly one cycle): the adder-subtractor evaluates combinationally on acc and opnd. At the end-of-cycle edge:
  - LOAD: acc <= opnd.
  - ADD/SUB: acc <= as_result.
  - CLR: acc <= 0.
  - res_data <= new acc, flags are registered, res_valid <= 1, go to WAIT.
- Flags, with a=acc (old), b=opnd, r=new acc:
  - ADD: ovf = (a[3]==b[3]) && (r[3]!=a[3]).
  - SUB: ovf = (a[3]!=b[3]) && (r[3]!=a[3]).
  - LOAD/CLR: carry = 0, ovf = 0.
  - zero and neg always derive from r.
- WAIT: res_* held stable while res_ready = 0.
  - res_valid && res_ready with no new command accepted: res_valid <= 0, go to IDLE.
  - Simultaneous result handshake and command accept: go to EXEC; res_valid deasserts for the EXEC cycle.
- cmd_valid in EXEC is ignored (cmd_ready = 0); the upstream holds it.
- Arithmetic is modulo 16; wrap-around is reported only via res_carry and res_ovf, and acc never saturates.

## Timing
- Reset values: state IDLE, acc 0, opnd 0, op_reg 00, res_valid 0, res_data 0, all flags 0. as_select is 0. cmd_ready is 0 during rst and 1 on the first cycle after rst deasserts.
- Reset mid-operation (EXEC or WAIT): the pending command and result are discarded, and the reset values are visible the cycle after the rst edge.
- Latency: a command accepted at edge t0 is executed in cycle t0..t1. res_valid is high from t1.
- Throughput: 2 cycles per command when res_ready is held high; otherwise limited by the downstream.
- as_x, as_y and as_select are combinational from registers only (no input-to-output path). Adder-subtractor path budget: one full cycle.
- Consumer rule: res_* may change only after an edge where res_valid && res_ready, or on reset.

## Test plan
- Reset, then LOAD 5 and ADD 3 -> res_data 8, carry 0, ovf 1, neg 1, zero 0. res_valid rises one cycle after each accept.
- Following SUB 8 -> as_select 1 during EXEC. res_data 0, carry 1, ovf 0, zero 1.
- LOAD 1 then ADD 0xF -> res_data 0, carry 1, ovf 0, zero 1 (wrap-around).
- CLR then SUB 1 -> res_data 0xF, carry 0 (borrow), neg 1, ovf 0. CLR ignores cmd_data = 0xA and gives res_data 0.
- Backpressure: hold res_ready low 3 cycles after a result with cmd_valid high -> res_* stable, cmd_ready 0. Raising res_ready accepts the next command on the same edge. Back-to-back ADD 1 ×4 from 0 -> results 1, 2, 3, 4 at a 2-cycle cadence.
- Assert rst during EXEC of ADD 7 (acc = 2) -> the next cycle shows acc 0, res_valid 0, cmd_ready 0. After release, cmd_ready is 1 and no stale result appears.
